seq_ctrl: RTL and testbench
===========================

Name: seq_ctrl

Overview:
Multicycle sequencer for the 4-bit-opcode CPU datapath (PC, IR, register file, ULA, data memory port). It steps each instruction through fetch, decode, execute, memory, writeback and PC-increment phases. It drives the datapath write enables, mux selects and ULA opcode, and handshakes with data memory. Illegal opcodes and (optionally) memory timeouts trap into a sticky error state.

Parameters:
TIMEOUT, 15, max MEM-state cycles waiting for MemAck before error (1..2^TW-1)
TW, 4, width of MEM wait counter

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  async active-low reset
CodOP  in  4  opcode from instruction register, stable from DECODE onward
Zero  in  1  ULA zero flag
MemAck  in  1  data memory done, sampled only in MEM
EscLR  out  1  instruction register write
EscCP  out  1  unconditional PC write
EscCondCP  out  1  PC write qualified by Zero (gated in datapath)
FonteCP  out  2  PC source: 00 ULA result, 01 branch target, 10 jump target
ULA_OP  out  4  ULA operation
ULA_A  out  1  ULA A select: 0 PC, 1 reg A
ULA_B  out  2  ULA B select: 00 reg B, 01 constant 1, 10 immediate
EscReg  out  1  register file write
MemReq  out  1  data memory request
MemWr  out  1  1 store / 0 load, valid with MemReq
Erro  out  1  sticky error flag
Estado  out  3  current state, for debug

Behaviour:
- Opcode classes: 0000-0101 ALU reg/reg; 0110-1000 ALU immediate; 1001 load; 1010 store; 1011 jump; 1100 branch-if-zero; 1101-1111 illegal.
- Moore FSM. Outputs decode from the state register plus op_q, an opcode copy latched in DECODE. Unlisted outputs are 0.
- States: INIT=7, FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, PCINC=5, ERR=6.
- Reset: RST_N low forces INIT immediately, op_q=0, counter=0, and all outputs 0 (Estado=111). This also applies mid-operation: MemReq drops asynchronously.
- INIT: next state FETCH.
- FETCH: EscLR=1. Next state DECODE.
- DECODE: latch op_q=CodOP. Next state ERR if illegal, else EXEC.
- EXEC, ALU reg/reg: ULA_OP=op_q, ULA_A=1, ULA_B=00. Next state WB.
- EXEC, ALU immediate: ULA_OP=op_q, ULA_A=1, ULA_B=10. Next state WB.
- EXEC, load/store: ULA_OP=0000, ULA_A=1, ULA_B=10 (address calc). Next state MEM.
- EXEC, jump: EscCP=1, FonteCP=10. Next state FETCH.
- EXEC, branch: ULA_OP=0001, ULA_A=1, ULA_B=00, EscCondCP=1, FonteCP=01. Next state FETCH if Zero=1, else PCINC.
- MEM: MemReq=1, MemWr=(op_q==1010). Hold until MemAck=1.
  - On MemAck: load goes to WB, store goes to PCINC.
  - Counter clears on MEM entry and increments each MEM cycle without ack.
- WB: EscReg=1. Next state PCINC.
- PCINC: ULA_OP=0000, ULA_A=0, ULA_B=01, FonteCP=00, EscCP=1. Next state FETCH.
- ERR: Erro=1, all write enables 0. Remains in ERR until reset.
- Latency from FETCH to next FETCH:
  - ALU: 5 cycles
  - jump: 3 cycles
  - branch taken / not taken: 3 / 4 cycles
  - load: 6+w cycles; store: 5+w cycles (w = wait cycles before ack)
- MemAck outside MEM is ignored. CodOP changes after DECODE have no effect.
- EscLR, EscCP, EscCondCP and EscReg are mutually exclusive every cycle.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: if MEM has lasted TIMEOUT cycles with MemAck=0 (counter==TIMEOUT-1 and no ack), next state is ERR and MemReq deasserts. MemAck=1 in that same cycle wins: normal transition.
- Undefined: no counter. MEM waits indefinitely. Erro is set only by illegal opcodes.

Test Plan:
- Reset pulse mid-MEM (MemReq=1) -> MemReq=0 asynchronously, Estado=111, all outputs 0. FETCH one cycle after release.
- CodOP=0010 -> EscLR, then ULA_OP=0010/ULA_A=1/ULA_B=00, then EscReg=1, then EscCP=1 with ULA_B=01. Back in FETCH after 5 cycles.
- CodOP=1100: Zero=1 -> EscCondCP=1, FonteCP=01, FETCH after 3 cycles. Zero=0 -> PCINC, FETCH after 4 cycles.
- CodOP=1001, MemAck after 3 waits -> MemReq=1/MemWr=0 for 4 cycles, then WB EscReg=1, then PCINC.
- CodOP=1110 -> ERR, Erro=1. Stays in ERR over 20 cycles with CodOP changing, until RST_N=0.
- With MEM_TIMEOUT_EN, CodOP=1010, MemAck=0 -> MemReq=1, MemWr=1 for 15 cycles, then ERR. Repeat with ack on cycle 15 -> PCINC, Erro=0.

Source files
------------

// File: rtl/seq_ctrl.sv
// Multicycle instruction sequencer: Moore FSM driving datapath enables, muxes and memory handshake.
// Optional MEM_TIMEOUT_EN traps into ERR when MemAck does not arrive within TIMEOUT MEM cycles.
module seq_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TW      = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] CodOP,
    input  logic       Zero,
    input  logic       MemAck,
    output logic       EscLR,
    output logic       EscCP,
    output logic       EscCondCP,
    output logic [1:0] FonteCP,
    output logic [3:0] ULA_OP,
    output logic       ULA_A,
    output logic [1:0] ULA_B,
    output logic       EscReg,
    output logic       MemReq,
    output logic       MemWr,
    output logic       Erro,
    output logic [2:0] Estado
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StPcInc  = 3'd5,
        StErr    = 3'd6,
        StInit   = 3'd7
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;

    logic is_rr, is_imm, is_load, is_store, is_jump, is_br;
    assign is_rr    = (op_q <= 4'd5);
    assign is_imm   = (op_q >= 4'd6) && (op_q <= 4'd8);
    assign is_load  = (op_q == 4'd9);
    assign is_store = (op_q == 4'd10);
    assign is_jump  = (op_q == 4'd11);
    assign is_br    = (op_q == 4'd12);

`ifdef MEM_TIMEOUT_EN
    logic [TW-1:0] cnt_q, cnt_d;
    logic          timeout;

    // Counter sits at zero outside MEM, so it is already clear on MEM entry.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != StMem) begin
            cnt_d = '0;
        end else if (!MemAck) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout = !MemAck && (cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StInit;
            op_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            StInit:   state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                op_d    = CodOP;
                state_d = (CodOP >= 4'd13) ? StErr : StExec;
            end
            StExec: begin
                if (is_rr || is_imm)          state_d = StWb;
                else if (is_load || is_store) state_d = StMem;
                else if (is_jump)             state_d = StFetch;
                else if (is_br)               state_d = Zero ? StFetch : StPcInc;
                else                          state_d = StErr;
            end
            StMem: begin
                if (MemAck) begin
                    state_d = is_load ? StWb : StPcInc;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    state_d = StErr;
                end
`endif
            end
            StWb:     state_d = StPcInc;
            StPcInc:  state_d = StFetch;
            StErr:    state_d = StErr;
            default:  state_d = StInit;
        endcase
    end

    always_comb begin
        EscLR     = 1'b0;
        EscCP     = 1'b0;
        EscCondCP = 1'b0;
        FonteCP   = 2'b00;
        ULA_OP    = 4'b0000;
        ULA_A     = 1'b0;
        ULA_B     = 2'b00;
        EscReg    = 1'b0;
        MemReq    = 1'b0;
        MemWr     = 1'b0;
        Erro      = 1'b0;
        Estado    = state_q;
        unique case (state_q)
            StFetch: EscLR = 1'b1;
            StExec: begin
                if (is_rr || is_imm) begin
                    ULA_OP = op_q;
                    ULA_A  = 1'b1;
                    ULA_B  = is_imm ? 2'b10 : 2'b00;
                end else if (is_load || is_store) begin
                    ULA_A = 1'b1;
                    ULA_B = 2'b10;
                end else if (is_jump) begin
                    EscCP   = 1'b1;
                    FonteCP = 2'b10;
                end else if (is_br) begin
                    ULA_OP    = 4'b0001;
                    ULA_A     = 1'b1;
                    EscCondCP = 1'b1;
                    FonteCP   = 2'b01;
                end
            end
            StMem: begin
                MemReq = 1'b1;
                MemWr  = is_store;
            end
            StWb:    EscReg = 1'b1;
            StPcInc: begin
                ULA_B = 2'b01;
                EscCP = 1'b1;
            end
            StErr:   Erro = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl; timeout scenarios run only when MEM_TIMEOUT_EN is defined.
module tb_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] CodOP = 4'd0;
    logic       Zero = 1'b0;
    logic       MemAck = 1'b0;
    logic       EscLR, EscCP, EscCondCP, EscReg, MemReq, MemWr, Erro, ULA_A;
    logic [1:0] FonteCP, ULA_B;
    logic [3:0] ULA_OP;
    logic [2:0] Estado;

    int errors = 0;
    int checks = 0;

    seq_ctrl #(.TIMEOUT(15), .TW(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .CodOP(CodOP), .Zero(Zero), .MemAck(MemAck),
        .EscLR(EscLR), .EscCP(EscCP), .EscCondCP(EscCondCP), .FonteCP(FonteCP),
        .ULA_OP(ULA_OP), .ULA_A(ULA_A), .ULA_B(ULA_B), .EscReg(EscReg),
        .MemReq(MemReq), .MemWr(MemWr), .Erro(Erro), .Estado(Estado)
    );

    always #5 CLK = ~CLK;

    logic [18:0] outs;
    assign outs = {EscLR, EscCP, EscCondCP, FonteCP, ULA_OP, ULA_A, ULA_B,
                   EscReg, MemReq, MemWr, Erro, Estado};

    function automatic logic [18:0] v(input logic lr, input logic cp, input logic cc,
                                      input logic [1:0] fc, input logic [3:0] op,
                                      input logic a, input logic [1:0] b, input logic rg,
                                      input logic rq, input logic wr, input logic er,
                                      input logic [2:0] st);
        return {lr, cp, cc, fc, op, a, b, rg, rq, wr, er, st};
    endfunction

    logic [18:0] VI, VF, VD, VW, VP, VE, VLS, VML, VMS;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        step();
        step();
        checks++;
        if (outs !== VI) begin errors++; $display("FAIL reset_hold got %h exp %h", outs, VI); end
        RST_N = 1'b1;
        checks++;
        if (outs !== VI) begin errors++; $display("FAIL reset_release got %h exp %h", outs, VI); end
        step();
        checks++;
        if (outs !== VF) begin errors++; $display("FAIL reset_fetch got %h exp %h", outs, VF); end
    endtask

    // MemAck held high throughout: must be ignored outside MEM.
    task automatic test_alu_rr();
        logic [18:0] e[$];
        e = '{VF, VD, v(0,0,0,2'b00,4'b0010,1,2'b00,0,0,0,0,3'd2), VW, VP, VF};
        CodOP = 4'b0010;
        MemAck = 1'b1;
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (outs !== e[i]) begin
                errors++;
                $display("FAIL alu_rr step%0d got %h exp %h", i, outs, e[i]);
            end
            if (i == 2) CodOP = 4'b1111;
            if (i < e.size() - 1) step();
        end
        MemAck = 1'b0;
    endtask

    task automatic test_alu_imm();
        logic [18:0] e[$];
        e = '{VF, VD, v(0,0,0,2'b00,4'b0111,1,2'b10,0,0,0,0,3'd2), VW, VP, VF};
        CodOP = 4'b0111;
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (outs !== e[i]) begin
                errors++;
                $display("FAIL alu_imm step%0d got %h exp %h", i, outs, e[i]);
            end
            if (i < e.size() - 1) step();
        end
    endtask

    task automatic test_jump();
        logic [18:0] e[$];
        e = '{VF, VD, v(0,1,0,2'b10,4'b0000,0,2'b00,0,0,0,0,3'd2), VF};
        CodOP = 4'b1011;
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (outs !== e[i]) begin
                errors++;
                $display("FAIL jump step%0d got %h exp %h", i, outs, e[i]);
            end
            if (i < e.size() - 1) step();
        end
    endtask

    task automatic test_branch(input logic z);
        logic [18:0] e[$];
        logic [18:0] ex;
        ex = v(0,0,1,2'b01,4'b0001,1,2'b00,0,0,0,0,3'd2);
        if (z) e = '{VF, VD, ex, VF};
        else   e = '{VF, VD, ex, VP, VF};
        CodOP = 4'b1100;
        Zero  = z;
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (outs !== e[i]) begin
                errors++;
                $display("FAIL branch_z%0d step%0d got %h exp %h", z, i, outs, e[i]);
            end
            if (i < e.size() - 1) step();
        end
        Zero = 1'b0;
    endtask

    // Load with three wait cycles, ack in the fourth MEM cycle.
    task automatic test_load();
        logic [18:0] e[$];
        e = '{VF, VD, VLS, VML, VML, VML, VML, VW, VP, VF};
        CodOP = 4'b1001;
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (outs !== e[i]) begin
                errors++;
                $display("FAIL load step%0d got %h exp %h", i, outs, e[i]);
            end
            MemAck = (i == 6);
            if (i < e.size() - 1) step();
        end
    endtask

    task automatic test_store();
        logic [18:0] e[$];
        e = '{VF, VD, VLS, VMS, VMS, VP, VF};
        CodOP = 4'b1010;
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (outs !== e[i]) begin
                errors++;
                $display("FAIL store step%0d got %h exp %h", i, outs, e[i]);
            end
            MemAck = (i == 4);
            if (i < e.size() - 1) step();
        end
    endtask

    task automatic test_reset_mid_mem();
        CodOP = 4'b1001;
        MemAck = 1'b0;
        step();
        step();
        step();
        checks++;
        if (outs !== VML) begin errors++; $display("FAIL mid_mem_enter got %h exp %h", outs, VML); end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if (outs !== VI) begin errors++; $display("FAIL mid_mem_async got %h exp %h", outs, VI); end
        step();
        RST_N = 1'b1;
        step();
        checks++;
        if (outs !== VF) begin errors++; $display("FAIL mid_mem_refetch got %h exp %h", outs, VF); end
    endtask

    task automatic test_illegal();
        CodOP = 4'b1110;
        step();
        step();
        checks++;
        if (outs !== VE) begin errors++; $display("FAIL illegal_err got %h exp %h", outs, VE); end
        for (int i = 0; i < 20; i++) begin
            CodOP  = 4'(i);
            MemAck = i[0];
            step();
            checks++;
            if (outs !== VE) begin
                errors++;
                $display("FAIL illegal_sticky cyc%0d got %h exp %h", i, outs, VE);
            end
        end
        MemAck = 1'b0;
        RST_N = 1'b0;
        #1;
        checks++;
        if (outs !== VI) begin errors++; $display("FAIL illegal_reset got %h exp %h", outs, VI); end
        step();
        RST_N = 1'b1;
        step();
        checks++;
        if (outs !== VF) begin errors++; $display("FAIL illegal_refetch got %h exp %h", outs, VF); end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout(input logic ack_last);
        logic [18:0] e[$];
        e = '{VF, VD, VLS};
        for (int i = 0; i < 15; i++) e.push_back(VMS);
        if (ack_last) begin
            e.push_back(VP);
            e.push_back(VF);
        end else begin
            e.push_back(VE);
        end
        CodOP = 4'b1010;
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (outs !== e[i]) begin
                errors++;
                $display("FAIL timeout_ack%0d step%0d got %h exp %h", ack_last, i, outs, e[i]);
            end
            MemAck = ack_last && (i == 17);
            if (i < e.size() - 1) step();
        end
        MemAck = 1'b0;
        if (!ack_last) begin
            RST_N = 1'b0;
            step();
            RST_N = 1'b1;
            step();
            checks++;
            if (outs !== VF) begin errors++; $display("FAIL timeout_refetch got %h exp %h", outs, VF); end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        VI  = v(0,0,0,2'b00,4'b0000,0,2'b00,0,0,0,0,3'd7);
        VF  = v(1,0,0,2'b00,4'b0000,0,2'b00,0,0,0,0,3'd0);
        VD  = v(0,0,0,2'b00,4'b0000,0,2'b00,0,0,0,0,3'd1);
        VW  = v(0,0,0,2'b00,4'b0000,0,2'b00,1,0,0,0,3'd4);
        VP  = v(0,1,0,2'b00,4'b0000,0,2'b01,0,0,0,0,3'd5);
        VE  = v(0,0,0,2'b00,4'b0000,0,2'b00,0,0,0,1,3'd6);
        VLS = v(0,0,0,2'b00,4'b0000,1,2'b10,0,0,0,0,3'd2);
        VML = v(0,0,0,2'b00,4'b0000,0,2'b00,0,1,0,0,3'd3);
        VMS = v(0,0,0,2'b00,4'b0000,0,2'b00,0,1,1,0,3'd3);
        #1;
        test_reset();
        test_alu_rr();
        test_alu_imm();
        test_jump();
        test_branch(1'b1);
        test_branch(1'b0);
        test_load();
        test_store();
        test_reset_mid_mem();
        test_illegal();
`ifdef MEM_TIMEOUT_EN
        test_timeout(1'b0);
        test_timeout(1'b1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
